// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_pkg
// Description : Shared state encoding and default parameter set for the
//               RISC-V run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_pkg;

   // Run controller state encoding
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RST_HOLD = 3'd1,
      ST_RUN      = 3'd2,
      ST_HALTED   = 3'd3,
      ST_TIMEOUT  = 3'd4
   } run_state_t;

   // Default parameter set
   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_RST_CYCLES  = 4;
   localparam int DEF_HALT_REPEAT = 3;

endpackage : cpu_run_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear and enable that sticks at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   // Clear has priority; increment stops once every bit is set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !(&count)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule : sat_counter
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_controller
// Description : Sequences core reset, counts run cycles and retired
//               instructions, and flags branch-to-self halt or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller
   import cpu_run_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int RST_CYCLES  = DEF_RST_CYCLES,
   parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  timeout_limit,
   input  logic              retire_valid,
   input  logic [ADDR_W-1:0] retire_pc,
   output logic              core_reset,
   output logic              running,
   output logic              done,
   output logic              timed_out,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  retired_count
);

   localparam int REP_W  = $clog2(HALT_REPEAT + 1);
   localparam int HOLD_W = $clog2(RST_CYCLES + 1);
   localparam logic [REP_W-1:0]  C_HALT_CNT = REP_W'(HALT_REPEAT);
   localparam logic [HOLD_W-1:0] C_HOLD_END = HOLD_W'(RST_CYCLES - 1);

   run_state_t        state;
   run_state_t        next_state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt;
   logic [REP_W-1:0]  rep_next;
   logic [ADDR_W-1:0] last_pc;
   logic [CNT_W-1:0]  limit_q;
   logic              enter_hold;
   logic              enter_run;
   logic              halt_hit;
   logic              timeout_hit;

   // Next-state decode; halt takes precedence over timeout in the same cycle
   always_comb begin
      next_state  = state;
      rep_next    = REP_W'(1);
      halt_hit    = 1'b0;
      timeout_hit = 1'b0;

      // rep_cnt of zero means no retire seen since the run began, so the
      // first retire always starts a fresh run of one even at PC 0
      if ((rep_cnt != '0) && (retire_pc == last_pc)) begin
         rep_next = rep_cnt + REP_W'(1);
      end
      halt_hit    = retire_valid && (rep_next == C_HALT_CNT);
      timeout_hit = (limit_q != '0) && (cycle_count == (limit_q - CNT_W'(1)));

      case (state)
         ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
            if (start) next_state = ST_RST_HOLD;
         end
         ST_RST_HOLD: begin
            if (hold_cnt == C_HOLD_END) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (halt_hit)         next_state = ST_HALTED;
            else if (timeout_hit) next_state = ST_TIMEOUT;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign enter_hold = (next_state == ST_RST_HOLD) && (state != ST_RST_HOLD);
   assign enter_run  = (next_state == ST_RUN) && (state == ST_RST_HOLD);

   // State register and reset-hold timer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
      end else begin
         state <= next_state;
         if (enter_hold) begin
            hold_cnt <= '0;
         end else if (state == ST_RST_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

   // Branch-to-self tracking and timeout limit capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt <= '0;
         last_pc <= '0;
         limit_q <= '0;
      end else begin
         if (enter_hold) begin
            rep_cnt <= '0;
            last_pc <= '0;
         end else if ((state == ST_RUN) && retire_valid) begin
            rep_cnt <= rep_next;
            last_pc <= retire_pc;
         end
         if (enter_run) begin
            limit_q <= timeout_limit;
         end
      end
   end

   // Outputs registered from the upcoming state so they line up with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_reset <= 1'b1;
         running    <= 1'b0;
         done       <= 1'b0;
         timed_out  <= 1'b0;
      end else begin
         core_reset <= (next_state != ST_RUN);
         running    <= (next_state == ST_RUN);
         done       <= (next_state == ST_HALTED);
         timed_out  <= (next_state == ST_TIMEOUT);
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_cycle_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (enter_hold),
      .enable  (state == ST_RUN),
      .count   (cycle_count)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_retire_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (enter_hold),
      .enable  ((state == ST_RUN) && retire_valid),
      .count   (retired_count)
   );

endmodule : cpu_run_controller
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_controller
// Description : Directed self-checking bench for cpu_run_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 32;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [CNT_W-1:0]  timeout_limit;
   logic              retire_valid;
   logic [ADDR_W-1:0] retire_pc;
   logic              core_reset;
   logic              running;
   logic              done;
   logic              timed_out;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  retired_count;

   int n_cmp;
   int n_bad;

   cpu_run_controller #(
      .ADDR_W      (ADDR_W),
      .CNT_W       (CNT_W),
      .RST_CYCLES  (4),
      .HALT_REPEAT (3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .timeout_limit (timeout_limit),
      .retire_valid  (retire_valid),
      .retire_pc     (retire_pc),
      .core_reset    (core_reset),
      .running       (running),
      .done          (done),
      .timed_out     (timed_out),
      .cycle_count   (cycle_count),
      .retired_count (retired_count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start and confirm a four-cycle core reset hold into RUN
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_cycle_clr", cycle_count, 0);
      check("hold_retire_clr", retired_count, 0);
      check("hold_done_clr", done, 0);
      check("hold_to_clr", timed_out, 0);
      check("hold_creset_0", core_reset, 1);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("hold_creset_n", core_reset, 1);
         check("hold_running_n", running, 0);
      end
      tick();
      check("run_creset", core_reset, 0);
      check("run_running", running, 1);
      check("run_cycle0", cycle_count, 0);
   endtask

   logic [ADDR_W-1:0] halt_pcs [5];
   logic [ADDR_W-1:0] tie_pcs  [6];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset_n       = 1'b0;
      start         = 1'b0;
      timeout_limit = '0;
      retire_valid  = 1'b0;
      retire_pc     = '0;
      halt_pcs = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
      tie_pcs  = '{32'h10, 32'h14, 32'h18, 32'h20, 32'h20, 32'h20};

      // Reset then idle
      repeat (3) tick();
      check("rst_creset", core_reset, 1);
      check("rst_running", running, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_creset", core_reset, 1);
         check("idle_running", running, 0);
         check("idle_cycles", cycle_count, 0);
         check("idle_retired", retired_count, 0);
      end

      // Halt on branch-to-self
      do_start();
      for (int i = 0; i < 5; i++) begin
         retire_valid = 1'b1;
         retire_pc    = halt_pcs[i];
         tick();
         if (i < 4) check("halt_not_yet", done, 0);
      end
      retire_valid = 1'b0;
      check("halt_done", done, 1);
      check("halt_retired", retired_count, 5);
      check("halt_cycles", cycle_count, 5);
      check("halt_creset", core_reset, 1);
      check("halt_running", running, 0);
      check("halt_to", timed_out, 0);
      repeat (3) tick();
      check("halt_frozen", cycle_count, 5);
      check("halt_sticky", done, 1);

      // Restart from HALTED into a timeout run
      timeout_limit = 32'd10;
      do_start();
      for (int i = 0; i < 10; i++) begin
         retire_valid = 1'b1;
         retire_pc    = 32'h100 + 32'(4 * i);
         tick();
         if (i == 8) begin
            check("to_not_yet", timed_out, 0);
            check("to_still_run", running, 1);
         end
      end
      retire_valid = 1'b0;
      check("to_flag", timed_out, 1);
      check("to_cycles", cycle_count, 10);
      check("to_retired", retired_count, 10);
      check("to_done", done, 0);
      check("to_creset", core_reset, 1);

      // Timeout disabled: 200 cycles, start mid-run ignored
      timeout_limit = '0;
      do_start();
      for (int i = 0; i < 200; i++) begin
         retire_valid = 1'b1;
         retire_pc    = 32'h1000 + 32'(4 * i);
         start        = (i == 50);
         tick();
      end
      start        = 1'b0;
      retire_valid = 1'b0;
      check("nolim_to", timed_out, 0);
      check("nolim_running", running, 1);
      check("nolim_cycles", cycle_count, 200);
      check("nolim_retired", retired_count, 200);

      // Asynchronous reset between clock edges
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_creset", core_reset, 1);
      check("areset_running", running, 0);
      check("areset_cycles", cycle_count, 0);
      check("areset_retired", retired_count, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check("areset_idle", core_reset, 1);

      // Halt and timeout in the same cycle
      timeout_limit = 32'd6;
      do_start();
      for (int i = 0; i < 6; i++) begin
         retire_valid = 1'b1;
         retire_pc    = tie_pcs[i];
         tick();
         if (i == 4) check("tie_not_yet", running, 1);
      end
      retire_valid = 1'b0;
      check("tie_done", done, 1);
      check("tie_to", timed_out, 0);
      check("tie_cycles", cycle_count, 6);
      check("tie_retired", retired_count, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_cpu_run_controller
`default_nettype wire
